// File: rtl/sound_generator.sv
// Event-driven sawtooth tone generator: each rising event edge starts a fixed-length
// ramp on dacCount whose step rate depends on the event; silence (0) otherwise.
module sound_generator #(
    parameter int unsigned GOOD_DIV   = 4,
    parameter int unsigned BAD_DIV    = 16,
    parameter int unsigned BUTTON_DIV = 2,
    parameter int unsigned DIR_DIV    = 8,
    parameter int unsigned DURATION   = 1024
) (
    input  logic       clk,
    input  logic       nRst_i,
    input  logic       goodColl_i,
    input  logic       badColl_i,
    input  logic       button_i,
    input  logic       direction_i,
    output logic [7:0] dacCount
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // All generator state lives in one struct so checkers can bind to a single signal.
    typedef struct packed {
        state_t      state;
        logic [15:0] divider;
        logic [15:0] prescaler;
        logic [15:0] duration;
        logic [7:0]  sample;
    } gen_regs_t;

    localparam logic [15:0] GOOD_DIV_W   = 16'(GOOD_DIV);
    localparam logic [15:0] BAD_DIV_W    = 16'(BAD_DIV);
    localparam logic [15:0] BUTTON_DIV_W = 16'(BUTTON_DIV);
    localparam logic [15:0] DIR_DIV_W    = 16'(DIR_DIV);
    localparam logic [15:0] DUR_LAST     = 16'(DURATION - 1);

    gen_regs_t   cur;
    gen_regs_t   nxt;
    logic [3:0]  evt_now;
    logic [3:0]  evt_prev;
    logic [3:0]  evt_rise;
    logic        trigger;
    logic [15:0] trig_div;

    // Bit order encodes priority: bad, good, button, direction.
    assign evt_now  = {badColl_i, goodColl_i, button_i, direction_i};
    assign evt_rise = evt_now & ~evt_prev;
    assign trigger  = |evt_rise;

    always_ff @(posedge clk or posedge nRst_i) begin
        if (nRst_i) begin
            evt_prev <= '0;
        end else begin
            evt_prev <= evt_now;
        end
    end

    always_comb begin
        trig_div = '0;
        if (evt_rise[3]) begin
            trig_div = BAD_DIV_W;
        end else if (evt_rise[2]) begin
            trig_div = GOOD_DIV_W;
        end else if (evt_rise[1]) begin
            trig_div = BUTTON_DIV_W;
        end else if (evt_rise[0]) begin
            trig_div = DIR_DIV_W;
        end
    end

    always_ff @(posedge clk or posedge nRst_i) begin
        if (nRst_i) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt = cur;
        if (trigger) begin
            nxt.state     = PLAY;
            nxt.divider   = trig_div;
            nxt.prescaler = '0;
            nxt.duration  = '0;
            nxt.sample    = '0;
        end else if (cur.state == PLAY) begin
            if (cur.prescaler == cur.divider - 16'd1) begin
                nxt.prescaler = '0;
                nxt.sample    = cur.sample + 8'd1;
            end else begin
                nxt.prescaler = cur.prescaler + 16'd1;
            end
            // End of tone wins over the sample step and parks the counters at zero.
            if (cur.duration == DUR_LAST) begin
                nxt.state     = IDLE;
                nxt.sample    = '0;
                nxt.prescaler = '0;
                nxt.duration  = '0;
            end else begin
                nxt.duration = cur.duration + 16'd1;
            end
        end else begin
            nxt.sample    = '0;
            nxt.prescaler = '0;
            nxt.duration  = '0;
        end
    end

    assign dacCount = cur.sample;

endmodule

// File: tb/tb_sound_generator.sv
// Scoreboard bench for sound_generator: two instances (short-tone defaults and a
// fast wrap-around build) checked against hand-computed samples per clock edge.
module tb_sound_generator;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic       rst;
    logic       a_good, a_bad, a_button, a_dir;
    logic       b_button;
    logic       b_zero;
    logic [7:0] dac_a, dac_b;

    sound_generator #(.DURATION(40)) dut_a (
        .clk         (tb_clk),
        .nRst_i      (rst),
        .goodColl_i  (a_good),
        .badColl_i   (a_bad),
        .button_i    (a_button),
        .direction_i (a_dir),
        .dacCount    (dac_a)
    );

    sound_generator #(.BUTTON_DIV(1), .DURATION(300)) dut_b (
        .clk         (tb_clk),
        .nRst_i      (rst),
        .goodColl_i  (b_zero),
        .badColl_i   (b_zero),
        .button_i    (b_button),
        .direction_i (b_zero),
        .dacCount    (dac_b)
    );

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];
    int         cyc_q[$];
    bit         sel_q[$];
    string      name_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // sel 0 = dut_a, 1 = dut_b; c = sample taken after rising edge number c.
    task automatic expect_at(input bit sel, input int c, input logic [7:0] v, input string n);
        sel_q.push_back(sel);
        cyc_q.push_back(c);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    always @(negedge tb_clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            automatic bit         s = sel_q.pop_front();
            automatic int         c = cyc_q.pop_front();
            automatic logic [7:0] v = exp_q.pop_front();
            automatic string      n = name_q.pop_front();
            if (c == cyc) begin
                check(n, s ? dac_b : dac_a, v);
            end else begin
                total_cnt++;
                $display("FAIL %s: sample for cycle %0d missed, now %0d", n, c, cyc);
            end
        end
    end

    initial begin
        int t;
        int t2;
        rst = 1'b0; a_good = 1'b0; a_bad = 1'b0; a_button = 1'b0; a_dir = 1'b0;
        b_button = 1'b0; b_zero = 1'b0;

        // Power-on reset
        #1 rst = 1'b1;
        #2;
        check("reset_async_a", dac_a, 8'd0);
        check("reset_async_b", dac_b, 8'd0);
        @(posedge tb_clk); #1;
        check("reset_hold_a", dac_a, 8'd0);
        @(negedge tb_clk);
        rst = 1'b0;
        expect_at(0, cyc + 1, 8'd0, "reset_release_a");
        expect_at(1, cyc + 1, 8'd0, "reset_release_b");
        repeat (3) @(negedge tb_clk);

        // Good tone, DIV 4, 40 cycles
        t = cyc + 1;
        a_good = 1'b1;
        for (int k = 0; k <= 3; k++) expect_at(0, t + k, 8'd0, "good_start");
        expect_at(0, t + 4,  8'd1, "good_first_step");
        expect_at(0, t + 36, 8'd9, "good_t36");
        expect_at(0, t + 39, 8'd9, "good_t39");
        for (int k = 40; k <= 45; k++) expect_at(0, t + k, 8'd0, "good_end");
        @(negedge tb_clk);
        a_good = 1'b0;
        repeat (50) @(negedge tb_clk);

        // Priority: bad beats button
        t = cyc + 1;
        a_bad = 1'b1; a_button = 1'b1;
        expect_at(0, t + 2,  8'd0, "prio_t2");
        expect_at(0, t + 15, 8'd0, "prio_t15");
        expect_at(0, t + 16, 8'd1, "prio_t16");
        expect_at(0, t + 32, 8'd2, "prio_t32");
        expect_at(0, t + 40, 8'd0, "prio_end");
        @(negedge tb_clk);
        a_bad = 1'b0; a_button = 1'b0;
        repeat (50) @(negedge tb_clk);

        // Retrigger: direction tone interrupted by button at dac=3
        t  = cyc + 1;
        t2 = t + 25;
        a_dir = 1'b1;
        expect_at(0, t + 8,   8'd1,  "dir_t8");
        expect_at(0, t + 24,  8'd3,  "dir_t24");
        expect_at(0, t2,      8'd0,  "retrig_t0");
        expect_at(0, t2 + 1,  8'd0,  "retrig_t1");
        expect_at(0, t2 + 2,  8'd1,  "retrig_t2");
        expect_at(0, t2 + 4,  8'd2,  "retrig_t4");
        expect_at(0, t2 + 16, 8'd8,  "retrig_past_old_end");
        expect_at(0, t2 + 39, 8'd19, "retrig_t39");
        expect_at(0, t2 + 40, 8'd0,  "retrig_end");
        @(negedge tb_clk);
        a_dir = 1'b0;
        repeat (24) @(negedge tb_clk);
        a_button = 1'b1;
        @(negedge tb_clk);
        a_button = 1'b0;
        repeat (45) @(negedge tb_clk);

        // Held input and 8-bit wrap on dut_b (DIV 1, 300 cycles)
        t = cyc + 1;
        b_button = 1'b1;
        expect_at(1, t,       8'd0,   "held_t0");
        expect_at(1, t + 1,   8'd1,   "held_t1");
        expect_at(1, t + 255, 8'd255, "held_t255");
        expect_at(1, t + 256, 8'd0,   "held_wrap");
        expect_at(1, t + 299, 8'd43,  "held_t299");
        expect_at(1, t + 300, 8'd0,   "held_end");
        expect_at(1, t + 310, 8'd0,   "held_no_retrigger");
        repeat (320) @(negedge tb_clk);
        b_button = 1'b0;
        repeat (3) @(negedge tb_clk);

        // Async reset mid-tone, and an input already high at release
        t = cyc + 1;
        a_good = 1'b1;
        expect_at(0, t + 8, 8'd2, "pre_abort");
        @(negedge tb_clk);
        a_good = 1'b0;
        repeat (9) @(negedge tb_clk);
        #2 rst = 1'b1;
        #1;
        check("abort_async", dac_a, 8'd0);
        b_button = 1'b1;
        @(negedge tb_clk);
        rst = 1'b0;
        expect_at(0, cyc + 1, 8'd0, "abort_stays_idle");
        expect_at(1, cyc + 1, 8'd0, "release_trig_t0");
        expect_at(1, cyc + 2, 8'd1, "release_trig_t1");
        expect_at(1, cyc + 3, 8'd2, "release_trig_t2");
        repeat (5) @(negedge tb_clk);
        b_button = 1'b0;

        total_cnt++;
        if (cyc_q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", cyc_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
